// File: rtl/mpu_bus_master_pkg.sv
// Shared definitions for the MPU register-bus master: FSM encoding, default
// bus timing and the control-register address map.
package mpu_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_STROBE_CYCLES = 2;
   localparam int DEF_HOLD_CYCLES   = 1;

   localparam logic [7:0] ADDR_MAIN_CTRL = 8'h00;
   localparam logic [7:0] ADDR_X_POS     = 8'h08;
   localparam logic [7:0] ADDR_Y_POS     = 8'h09;
   localparam logic [7:0] ADDR_X_OFFSET  = 8'h0c;
   localparam logic [7:0] ADDR_Y_OFFSET  = 8'h0d;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mpu_bus_master.sv
// Single-word initiator for the asynchronous MPU register bus with programmable
// setup / strobe / hold phases, read-data capture and a completion pulse.
//
// state     | meaning
// ST_IDLE   | ready for a request, bus released, en low
// ST_SETUP  | en/addr/be (and write data) stable ahead of the strobe
// ST_STROBE | rd or wr asserted; read data sampled on the last edge
// ST_HOLD   | strobe dropped, en/addr/be/write data held
module mpu_bus_master
   import mpu_bus_master_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 16,
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_be,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  bus_en,
   output logic                  bus_rd,
   output logic                  bus_wr,
   output logic [1:0]            bus_be,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   inout  wire  [DATA_WIDTH-1:0] bus_data
);

   localparam int MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  r_write;
   logic                  r_oe;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_rsp_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_rsp_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_STROBE;
               w_cnt_nxt   = STROBE_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = HOLD_LOAD;
               w_capture   = ~r_write;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_rsp_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bus outputs are computed from the next state so they change on the same
   // edge as the phase, without any combinational path from req_* to bus_*.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_oe      <= 1'b0;
         r_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         bus_en    <= 1'b0;
         bus_rd    <= 1'b0;
         bus_wr    <= 1'b0;
         bus_be    <= '0;
         bus_addr  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         rsp_valid <= w_rsp_nxt;
         if (w_accept) begin
            r_write  <= req_write;
            r_wdata  <= req_wdata;
            bus_be   <= req_be;
            bus_addr <= req_addr;
         end
         if (w_capture) begin
            rsp_rdata <= bus_data;
         end
         bus_en <= (w_state_nxt != ST_IDLE);
         bus_rd <= (w_state_nxt == ST_STROBE) && !r_write;
         bus_wr <= (w_state_nxt == ST_STROBE) && r_write;
         r_oe   <= (w_state_nxt != ST_IDLE) && (w_accept ? req_write : r_write);
      end
   end

   assign req_ready = (r_state == ST_IDLE) && !reset;
   assign bus_data  = r_oe ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mpu_bus_master.sv
// Bench for mpu_bus_master: two instances (default and stretched timing), each
// on its own bus with a register-file responder, checked against a word model.
module tb_mpu_bus_master;
   import mpu_bus_master_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_write [2];
   logic [1:0]  req_be    [2];
   logic [7:0]  req_addr  [2];
   logic [15:0] req_wdata [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [15:0] rsp_rdata [2];
   logic        bus_en    [2];
   logic        bus_rd    [2];
   logic        bus_wr    [2];
   logic [1:0]  bus_be    [2];
   logic [7:0]  bus_addr  [2];
   wire  [15:0] bus_data0;
   wire  [15:0] bus_data1;

   mpu_bus_master u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .bus_en(bus_en[0]), .bus_rd(bus_rd[0]), .bus_wr(bus_wr[0]),
      .bus_be(bus_be[0]), .bus_addr(bus_addr[0]), .bus_data(bus_data0)
   );

   mpu_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .bus_en(bus_en[1]), .bus_rd(bus_rd[1]), .bus_wr(bus_wr[1]),
      .bus_be(bus_be[1]), .bus_addr(bus_addr[1]), .bus_data(bus_data1)
   );

   // Register-file responders: drive on en&rd, latch on the falling edge of wr.
   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic [15:0] x_pos, y_pos;
   logic [15:0] rv0, rv1;

   always_comb begin
      if (bus_addr[0] == ADDR_X_POS)      rv0 = x_pos;
      else if (bus_addr[0] == ADDR_Y_POS) rv0 = y_pos;
      else                                rv0 = mem0[bus_addr[0]];
      if (bus_addr[1] == ADDR_X_POS)      rv1 = x_pos;
      else if (bus_addr[1] == ADDR_Y_POS) rv1 = y_pos;
      else                                rv1 = mem1[bus_addr[1]];
   end

   assign bus_data0 = (bus_en[0] && bus_rd[0]) ? rv0 : 16'hzzzz;
   assign bus_data1 = (bus_en[1] && bus_rd[1]) ? rv1 : 16'hzzzz;

   always @(negedge bus_wr[0]) begin
      if (bus_en[0]) begin
         if (bus_be[0][0]) mem0[bus_addr[0]][7:0]  = bus_data0[7:0];
         if (bus_be[0][1]) mem0[bus_addr[0]][15:8] = bus_data0[15:8];
      end
   end

   always @(negedge bus_wr[1]) begin
      if (bus_en[1]) begin
         if (bus_be[1][0]) mem1[bus_addr[1]][7:0]  = bus_data1[7:0];
         if (bus_be[1][1]) mem1[bus_addr[1]][15:8] = bus_data1[15:8];
      end
   end

   // Reference model: what each register should hold after byte-lane merges.
   logic [15:0] exp_mem [2][256];
   int total = 0;
   int bad   = 0;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = old;
      if (be[0]) r[7:0]  = wd[7:0];
      if (be[1]) r[15:8] = wd[15:8];
      return r;
   endfunction

   function automatic logic [15:0] exp_read(input int d, input logic [7:0] a);
      if (a == ADDR_X_POS) return x_pos;
      if (a == ADDR_Y_POS) return y_pos;
      return exp_mem[d][a];
   endfunction

   // Runs one request; reports latency from accept edge to rsp_valid, cycles of
   // en/wr/rd, and cycles where the read bus did not carry the responder value.
   task automatic txn(input int d, input logic w, input logic [1:0] be, input logic [7:0] a,
                      input logic [15:0] wd, output logic [15:0] rd, output int lat,
                      output int en_n, output int wr_n, output int rd_n, output int clash);
      int k;
      logic [15:0] bd, rv;
      lat = 0; en_n = 0; wr_n = 0; rd_n = 0; clash = 0;
      @(negedge clk);
      req_write[d] = w; req_be[d] = be; req_addr[d] = a; req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      k = 0;
      while (!req_ready[d] && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         total++; bad++;
         $display("FAIL accept_timeout dut=%0d got ready=0 want ready=1", d);
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         lat++;
         bd = (d == 0) ? bus_data0 : bus_data1;
         rv = (d == 0) ? rv0 : rv1;
         if (bus_en[d]) en_n++;
         if (bus_wr[d]) wr_n++;
         if (bus_rd[d]) begin
            rd_n++;
            if (bd !== rv) clash++;
         end
         if (rsp_valid[d]) break;
      end
      lat = lat - 1;
      if (!rsp_valid[d]) begin
         total++; bad++;
         $display("FAIL rsp_timeout dut=%0d got rsp_valid=0 want 1", d);
      end
      rd = rsp_rdata[d];
      if (w) exp_mem[d][a] = merge(exp_mem[d][a], wd, be);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (req_ready[d] !== 1'b0) begin bad++; $display("FAIL reset_ready dut=%0d got %b want 0", d, req_ready[d]); end
         total++;
         if ({bus_en[d], bus_rd[d], bus_wr[d], rsp_valid[d]} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes dut=%0d got %b want 0000", d, {bus_en[d], bus_rd[d], bus_wr[d], rsp_valid[d]});
         end
         total++;
         if ({bus_be[d], bus_addr[d], rsp_rdata[d]} !== 26'h0) begin
            bad++; $display("FAIL reset_regs dut=%0d got be=%h addr=%h rdata=%h want 0", d, bus_be[d], bus_addr[d], rsp_rdata[d]);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL ready_after_reset got %b want 1", req_ready[0]); end
   endtask

   task automatic test_write_read();
      logic [15:0] rd;
      int lat, en_n, wr_n, rd_n, clash;
      txn(0, 1'b1, 2'b11, ADDR_X_OFFSET, 16'h0155, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (lat != 4) begin bad++; $display("FAIL wr_latency got %0d want 4", lat); end
      total++;
      if (wr_n != 2 || rd_n != 0) begin bad++; $display("FAIL wr_strobe got wr=%0d rd=%0d want wr=2 rd=0", wr_n, rd_n); end
      total++;
      if (en_n != 4) begin bad++; $display("FAIL wr_en_width got %0d want 4", en_n); end
      txn(0, 1'b0, 2'b11, ADDR_X_OFFSET, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h0155) begin bad++; $display("FAIL rd_xoff got %h want 0155", rd); end
      total++;
      if (lat != 4 || rd_n != 2 || wr_n != 0) begin
         bad++; $display("FAIL rd_timing got lat=%0d rd=%0d wr=%0d want 4/2/0", lat, rd_n, wr_n);
      end
      txn(0, 1'b1, 2'b11, ADDR_MAIN_CTRL, 16'h5A5A, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h0155) begin bad++; $display("FAIL rdata_kept_on_write got %h want 0155", rd); end
   endtask

   task automatic test_byte_enables();
      logic [15:0] rd;
      int lat, en_n, wr_n, rd_n, clash;
      txn(0, 1'b1, 2'b01, ADDR_Y_OFFSET, 16'hAA77, rd, lat, en_n, wr_n, rd_n, clash);
      txn(0, 1'b0, 2'b11, ADDR_Y_OFFSET, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h0077) begin bad++; $display("FAIL be_low got %h want 0077", rd); end
      txn(0, 1'b1, 2'b10, ADDR_Y_OFFSET, 16'h0300, rd, lat, en_n, wr_n, rd_n, clash);
      txn(0, 1'b0, 2'b11, ADDR_Y_OFFSET, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h0377) begin bad++; $display("FAIL be_high got %h want 0377", rd); end
      txn(0, 1'b1, 2'b00, ADDR_Y_OFFSET, 16'hFFFF, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (lat != 4 || wr_n != 2) begin bad++; $display("FAIL be_none_cycle got lat=%0d wr=%0d want 4/2", lat, wr_n); end
      txn(0, 1'b0, 2'b11, ADDR_Y_OFFSET, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h0377) begin bad++; $display("FAIL be_none_data got %h want 0377", rd); end
   endtask

   task automatic test_xpos();
      logic [15:0] rd;
      int lat, en_n, wr_n, rd_n, clash;
      x_pos = 16'h01F3;
      txn(0, 1'b0, 2'b11, ADDR_X_POS, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (rd !== 16'h01F3) begin bad++; $display("FAIL xpos_read got %h want 01F3", rd); end
      total++;
      if (clash != 0) begin bad++; $display("FAIL xpos_bus_clash got %0d cycles want 0", clash); end
   endtask

   task automatic test_back_to_back();
      int phase = 0, gap = 0, seen = 0, overlap = 0, acc2 = -1;
      @(negedge clk);
      req_write[0] = 1'b1; req_be[0] = 2'b11; req_addr[0] = ADDR_MAIN_CTRL; req_wdata[0] = 16'h1234;
      req_valid[0] = 1'b1;
      for (int k = 0; k < 50 && !req_ready[0]; k++) @(negedge clk);
      @(posedge clk);
      #1;
      exp_mem[0][ADDR_MAIN_CTRL] = 16'h1234;
      req_write[0] = 1'b0; req_addr[0] = ADDR_MAIN_CTRL;
      for (int c = 0; c < 40 && seen < 2; c++) begin
         @(negedge clk);
         if (bus_rd[0] && bus_wr[0]) overlap++;
         if (phase == 0 && !bus_en[0]) phase = 1;
         if (phase == 1) begin
            if (bus_en[0]) phase = 2;
            else gap++;
         end
         if (rsp_valid[0]) seen++;
         if (req_valid[0] && req_ready[0]) begin
            acc2 = rsp_valid[0] ? 1 : 0;
            @(posedge clk);
            #1 req_valid[0] = 1'b0;
         end
      end
      total++;
      if (acc2 != 1) begin bad++; $display("FAIL b2b_accept_in_rsp got %0d want 1", acc2); end
      total++;
      if (gap != 1) begin bad++; $display("FAIL b2b_en_gap got %0d want 1", gap); end
      total++;
      if (overlap != 0 || seen != 2) begin bad++; $display("FAIL b2b_overlap got overlap=%0d rsp=%0d want 0/2", overlap, seen); end
      total++;
      if (rsp_rdata[0] !== exp_read(0, ADDR_MAIN_CTRL)) begin
         bad++; $display("FAIL b2b_rdata got %h want %h", rsp_rdata[0], exp_read(0, ADDR_MAIN_CTRL));
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, wd;
      logic [7:0]  a;
      logic [1:0]  be;
      logic        w;
      int lat, en_n, wr_n, rd_n, clash, errs;
      logic [7:0] addrs [5];
      addrs[0] = ADDR_MAIN_CTRL; addrs[1] = ADDR_X_OFFSET; addrs[2] = ADDR_Y_OFFSET;
      addrs[3] = ADDR_X_POS;     addrs[4] = ADDR_Y_POS;
      y_pos = 16'h0042;
      for (int i = 0; i < 24; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = w ? addrs[$urandom_range(0, 2)] : addrs[$urandom_range(0, 4)];
         be = 2'($urandom_range(0, 3));
         wd = 16'($urandom);
         txn(0, w, be, a, wd, rd, lat, en_n, wr_n, rd_n, clash);
         errs = 0;
         if (lat != 4) errs++;
         if (w && (wr_n != 2 || rd_n != 0)) errs++;
         if (!w && (rd_n != 2 || wr_n != 0 || rd !== exp_read(0, a))) errs++;
         if (clash != 0) errs++;
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL rand_%0d w=%b a=%h be=%b got rd=%h lat=%0d wr=%0d rdn=%0d clash=%0d want rd=%h lat=4",
                     i, w, a, be, rd, lat, wr_n, rd_n, clash, exp_read(0, a));
         end
      end
   endtask

   task automatic test_reset_mid();
      int k, spurious = 0;
      @(negedge clk);
      req_write[0] = 1'b1; req_be[0] = 2'b11; req_addr[0] = ADDR_MAIN_CTRL; req_wdata[0] = 16'hC0DE;
      req_valid[0] = 1'b1;
      for (int j = 0; j < 50 && !req_ready[0]; j++) @(negedge clk);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      k = 0;
      while (!bus_wr[0] && k < 20) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (!bus_wr[0]) begin bad++; $display("FAIL mid_reach_strobe got wr=0 want 1"); end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({bus_en[0], bus_rd[0], bus_wr[0], rsp_valid[0]} !== 4'b0000) begin
         bad++; $display("FAIL mid_reset_drop got %b want 0000", {bus_en[0], bus_rd[0], bus_wr[0], rsp_valid[0]});
      end
      total++;
      if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got %b want 0", req_ready[0]); end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL mid_ready_after got %b want 1", req_ready[0]); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid[0] || bus_en[0]) spurious++;
      end
      total++;
      if (spurious != 0) begin bad++; $display("FAIL mid_no_rsp got %0d cycles want 0", spurious); end
      exp_mem[0][ADDR_MAIN_CTRL] = mem0[ADDR_MAIN_CTRL];
   endtask

   task automatic test_params();
      logic [15:0] rd;
      int lat, en_n, wr_n, rd_n, clash;
      txn(1, 1'b1, 2'b11, ADDR_Y_OFFSET, 16'hBEEF, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (lat != 7 || en_n != 7 || wr_n != 3) begin
         bad++; $display("FAIL p_write got lat=%0d en=%0d wr=%0d want 7/7/3", lat, en_n, wr_n);
      end
      txn(1, 1'b0, 2'b11, ADDR_Y_OFFSET, 16'h0000, rd, lat, en_n, wr_n, rd_n, clash);
      total++;
      if (lat != 7 || en_n != 7 || rd_n != 3) begin
         bad++; $display("FAIL p_read_timing got lat=%0d en=%0d rd=%0d want 7/7/3", lat, en_n, rd_n);
      end
      total++;
      if (rd !== 16'hBEEF) begin bad++; $display("FAIL p_read_data got %h want BEEF", rd); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_be[d] = 2'b00;
         req_addr[d] = 8'h00; req_wdata[d] = 16'h0000;
      end
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 16'h0000; mem1[i] = 16'h0000;
         exp_mem[0][i] = 16'h0000; exp_mem[1][i] = 16'h0000;
      end
      x_pos = 16'h0000;
      y_pos = 16'h0000;
      reset = 1'b1;
      test_reset();
      test_write_read();
      test_byte_enables();
      test_xpos();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_params();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
